stream_width_converter: RTL and testbench
=========================================

STREAM_WIDTH_CONVERTER -- requirements
Module: stream_width_converter

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 128, upstream data width in bits.
REQ-002 SHALL have parameter OUT_WIDTH, default 32, downstream data width in bits.
REQ-003 SHALL have parameter DEPTH, default 4, input buffer entries (IN_WIDTH each), power of two, >=2.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port ap_start  input  1  run enable; low freezes all handshakes.
REQ-007 SHALL have port din  input  IN_WIDTH  upstream data.
REQ-008 SHALL have port vld_in  input  1  upstream valid.
REQ-009 SHALL have port rdy_upward  output  1  upstream ready.
REQ-010 SHALL have port dout  output  OUT_WIDTH  downstream data.
REQ-011 SHALL have port vld_out  output  1  downstream valid.
REQ-012 SHALL have port rdy_downward  input  1  downstream ready.
REQ-013 SHALL have port flush  input  1  up mode: emit partially assembled word.
REQ-014 SHALL have port dout_slices  output  clog2(RATIO+1)  number of valid OUT slices in dout (RATIO for full word).
REQ-015 SHALL have port level  output  clog2(DEPTH+1)  input buffer occupancy.

Function
REQ-016 SHALL derive mode at elaboration: DOWN if IN_WIDTH>OUT_WIDTH, UP if OUT_WIDTH>IN_WIDTH, PASS if equal; RATIO = larger/smaller width.
REQ-017 SHALL fail elaboration if the larger width is not an integer multiple of the smaller.
REQ-018 SHALL accept an input word on the rising edge where vld_in && rdy_upward; rdy_upward = ap_start && (level != DEPTH), no bypass when full.
REQ-019 SHALL keep level unchanged on same-cycle accept and pop; increment/decrement otherwise; pointers wrap modulo DEPTH.
REQ-020 SHALL transfer an output word on the rising edge where vld_out && rdy_downward; vld_out gated by ap_start.
REQ-021 DOWN: dout = head[idx*OUT_WIDTH +: OUT_WIDTH], LSB slice first; vld_out = ap_start && level!=0; idx increments per transfer; at idx=RATIO-1 head popped, idx wraps to 0; dout_slices = RATIO... (1 slice per beat) SHALL read 1.
REQ-022 UP: packer pops head into slice fill position (LSB first) each cycle that buffer non-empty, ap_start high, and output register free or being transferred this cycle; after RATIO slices output register valid, dout_slices = RATIO.
REQ-023 UP flush: when flush high, fill>0, buffer empty, output register free: output register loads partial word, unfilled slices zero, dout_slices = fill; fill resets to 0; flush with fill=0 is ignored.
REQ-024 PASS: dout = head, pop per transfer, dout_slices = 1.
REQ-025 Latency: word accepted at edge k SHALL be visible at dout no earlier than after edge k+1 (DOWN/PASS: vld_out high in cycle after k; UP: one further cycle for last slice).
REQ-026 dout and dout_slices SHALL hold stable while vld_out && !rdy_downward.
REQ-027 ap_start low SHALL freeze idx, fill, pointers and output register; no data lost.
REQ-028 Throughput: DOWN one OUT beat per cycle; UP one IN slice per cycle sustained.

Reset
REQ-029 On reset assertion SHALL immediately force rdy_upward=0, vld_out=0, level=0, dout=0, dout_slices=0, idx=0, fill=0; buffered and partial data discarded, also mid-word.
REQ-030 After release SHALL resume with empty buffer on first edge with ap_start high.

Structure
REQ-031 Shared package SHALL hold mode enum {MODE_DOWN, MODE_UP, MODE_PASS}, ratio/mode functions and clog2 helper.
REQ-032 Input buffer SHALL be sub-module conv_fifo (DEPTH x IN_WIDTH, registered, level output); converter logic in top.

Verification
REQ-033 DOWN 128->32: push 0x44444444_33333333_22222222_11111111, rdy_downward=1 -> dout 0x11111111,0x22222222,0x33333333,0x44444444 on four consecutive cycles.
REQ-034 UP 32->128: push 0xA,0xB,0xC,0xD -> one beat 0x0000000D_0000000C_0000000B_0000000A, dout_slices=4.
REQ-035 UP flush: push 0x1,0x2, assert flush -> dout 0x00000000_00000000_00000002_00000001, dout_slices=2.
REQ-036 Full/backpressure DEPTH=4: rdy_downward=0, push 5 words -> 4 accepted, rdy_upward=0, level=4; release -> all data in order, none lost.
REQ-037 Reset mid-word DOWN after 2 of 4 slices -> vld_out=0, level=0 immediately; next word starts at slice 0.
REQ-038 ap_start dropped mid-stream for 3 cycles -> no handshakes, dout held, stream resumes identically.

Source files
------------

// File: rtl/stream_width_converter_pkg.sv
// Shared types and elaboration helpers for the stream width converter.
// Mode/ratio are fixed at elaboration from the two port widths.
package stream_width_converter_pkg;

  typedef enum logic [1:0] {
    MODE_DOWN,
    MODE_UP,
    MODE_PASS
  } mode_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic mode_e conv_mode(input int iw, input int ow);
    if (iw > ow) return MODE_DOWN;
    if (ow > iw) return MODE_UP;
    return MODE_PASS;
  endfunction

  function automatic int conv_ratio(input int iw, input int ow);
    return (iw > ow) ? iw / ow : ow / iw;
  endfunction

  function automatic bit is_multiple(input int iw, input int ow);
    return (iw > ow) ? (iw % ow == 0) : (ow % iw == 0);
  endfunction

endpackage

// File: rtl/stream_width_converter_fifo.sv
// Input buffer: DEPTH x WIDTH registered FIFO with occupancy output.
// Caller guarantees no push when full and no pop when empty.
module conv_fifo
  import stream_width_converter_pkg::*;
#(
  parameter int WIDTH = 128,
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        push,
  input  logic [WIDTH-1:0]            push_data,
  input  logic                        pop,
  output logic [WIDTH-1:0]            head,
  output logic [clog2(DEPTH+1)-1:0]   level,
  output logic                        full,
  output logic                        empty
);

  localparam int AW = (DEPTH > 1) ? clog2(DEPTH) : 1;
  localparam int LW = clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage carries no reset; consumers gate on empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign level = level_q;
  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);

endmodule

// File: rtl/stream_width_converter.sv
// Valid/ready stream width converter: splits (DOWN), packs (UP) or
// passes words through a small input buffer.
module stream_width_converter
  import stream_width_converter_pkg::*;
#(
  parameter int IN_WIDTH  = 128,
  parameter int OUT_WIDTH = 32,
  parameter int DEPTH     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ap_start,
  input  logic [IN_WIDTH-1:0]  din,
  input  logic                 vld_in,
  output logic                 rdy_upward,
  output logic [OUT_WIDTH-1:0] dout,
  output logic                 vld_out,
  input  logic                 rdy_downward,
  input  logic                 flush,
  output logic [clog2(conv_ratio(IN_WIDTH, OUT_WIDTH)+1)-1:0] dout_slices,
  output logic [clog2(DEPTH+1)-1:0] level
);

  localparam mode_e MODE  = conv_mode(IN_WIDTH, OUT_WIDTH);
  localparam int    RATIO = conv_ratio(IN_WIDTH, OUT_WIDTH);
  localparam int    SW    = clog2(RATIO + 1);
  localparam int    IW    = (RATIO > 1) ? clog2(RATIO) : 1;

  if (!is_multiple(IN_WIDTH, OUT_WIDTH)) begin : g_bad_ratio
    $error("larger width must be an integer multiple of the smaller");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of two >= 2");
  end

  logic                push;
  logic                pop;
  logic                full;
  logic                empty;
  logic [IN_WIDTH-1:0] head;

  // Reset is folded in so ready drops the instant reset asserts.
  assign rdy_upward = ap_start && !reset && !full;
  assign push       = vld_in && rdy_upward;

  conv_fifo #(
    .WIDTH(IN_WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_data(din),
    .pop      (pop),
    .head     (head),
    .level    (level),
    .full     (full),
    .empty    (empty)
  );

  if (MODE == MODE_DOWN) begin : g_down
    logic [IW-1:0] idx_q, idx_d;
    logic          xfer;
    logic          last;
    logic          unused_flush;

    assign unused_flush = flush;
    assign vld_out      = ap_start && !empty;
    assign xfer         = vld_out && rdy_downward;
    assign last         = (idx_q == IW'(RATIO - 1));
    assign pop          = xfer && last;
    assign dout         = empty ? '0 : head[idx_q*OUT_WIDTH +: OUT_WIDTH];
    assign dout_slices  = empty ? '0 : SW'(1);

    always_comb begin
      idx_d = idx_q;
      if (xfer) idx_d = last ? '0 : idx_q + IW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) idx_q <= '0;
      else       idx_q <= idx_d;
    end
  end else if (MODE == MODE_UP) begin : g_up
    logic [OUT_WIDTH-1:0] data_q, data_d;
    logic [OUT_WIDTH-1:0] acc_q, acc_d;
    logic [SW-1:0]        slices_q, slices_d;
    logic [IW-1:0]        fill_q, fill_d;
    logic                 ovld_q, ovld_d;
    logic                 xfer;
    logic                 out_free;
    logic                 do_flush;

    assign vld_out  = ap_start && ovld_q;
    assign xfer     = vld_out && rdy_downward;
    assign out_free = !ovld_q || xfer;
    assign pop      = ap_start && !empty && out_free;
    assign do_flush = ap_start && flush && (fill_q != '0)
                      && empty && out_free;

    always_comb begin
      data_d   = data_q;
      acc_d    = acc_q;
      slices_d = slices_q;
      fill_d   = fill_q;
      ovld_d   = ovld_q;
      if (xfer) ovld_d = 1'b0;
      if (pop) begin
        acc_d[fill_q*IN_WIDTH +: IN_WIDTH] = head;
        if (fill_q == IW'(RATIO - 1)) begin
          data_d   = acc_d;
          ovld_d   = 1'b1;
          slices_d = SW'(RATIO);
          fill_d   = '0;
          acc_d    = '0;
        end else begin
          fill_d = fill_q + IW'(1);
        end
      end else if (do_flush) begin
        // Unfilled upper slices are already zero in the accumulator.
        data_d   = acc_q;
        ovld_d   = 1'b1;
        slices_d = SW'(fill_q);
        fill_d   = '0;
        acc_d    = '0;
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        data_q   <= '0;
        acc_q    <= '0;
        slices_q <= '0;
        fill_q   <= '0;
        ovld_q   <= 1'b0;
      end else begin
        data_q   <= data_d;
        acc_q    <= acc_d;
        slices_q <= slices_d;
        fill_q   <= fill_d;
        ovld_q   <= ovld_d;
      end
    end

    assign dout        = data_q;
    assign dout_slices = slices_q;
  end else begin : g_pass
    logic unused_flush;

    assign unused_flush = flush;
    assign vld_out      = ap_start && !empty;
    assign pop          = vld_out && rdy_downward;
    assign dout         = empty ? '0 : head;
    assign dout_slices  = empty ? '0 : SW'(1);
  end

endmodule

// File: tb/tb_stream_width_converter.sv
// Directed bench: DOWN 128->32, UP 32->128 and PASS 32->32 instances.
module tb_stream_width_converter;

  logic clk = 1'b0;
  logic reset;
  logic ap_start;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  logic [127:0] d_din;
  logic         d_vld, d_rdy_dn, d_flush, d_rdy_up, d_vout;
  logic [31:0]  d_dout;
  logic [2:0]   d_sl, d_lvl;

  logic [31:0]  u_din;
  logic         u_vld, u_rdy_dn, u_flush, u_rdy_up, u_vout;
  logic [127:0] u_dout;
  logic [2:0]   u_sl, u_lvl;

  logic [31:0]  p_din, p_dout;
  logic         p_vld, p_rdy_dn, p_flush, p_rdy_up, p_vout;
  logic [0:0]   p_sl;
  logic [2:0]   p_lvl;

  stream_width_converter #(.IN_WIDTH(128), .OUT_WIDTH(32), .DEPTH(4)) u_down (
    .clk(clk), .reset(reset), .ap_start(ap_start), .din(d_din),
    .vld_in(d_vld), .rdy_upward(d_rdy_up), .dout(d_dout),
    .vld_out(d_vout), .rdy_downward(d_rdy_dn), .flush(d_flush),
    .dout_slices(d_sl), .level(d_lvl));

  stream_width_converter #(.IN_WIDTH(32), .OUT_WIDTH(128), .DEPTH(4)) u_up (
    .clk(clk), .reset(reset), .ap_start(ap_start), .din(u_din),
    .vld_in(u_vld), .rdy_upward(u_rdy_up), .dout(u_dout),
    .vld_out(u_vout), .rdy_downward(u_rdy_dn), .flush(u_flush),
    .dout_slices(u_sl), .level(u_lvl));

  stream_width_converter #(.IN_WIDTH(32), .OUT_WIDTH(32), .DEPTH(4)) u_pass (
    .clk(clk), .reset(reset), .ap_start(ap_start), .din(p_din),
    .vld_in(p_vld), .rdy_upward(p_rdy_up), .dout(p_dout),
    .vld_out(p_vout), .rdy_downward(p_rdy_dn), .flush(p_flush),
    .dout_slices(p_sl), .level(p_lvl));

  function automatic logic [31:0] slc(int i, int j);
    return 32'hA000_0000 | 32'(i << 8) | 32'(j);
  endfunction

  function automatic logic [127:0] mkw(int i);
    logic [127:0] w;
    for (int j = 0; j < 4; j++) w[j*32 +: 32] = slc(i, j);
    return w;
  endfunction

  task automatic test_reset();
    reset = 1'b1; ap_start = 1'b1;
    d_din = '0; d_vld = 0; d_rdy_dn = 0; d_flush = 0;
    u_din = '0; u_vld = 0; u_rdy_dn = 0; u_flush = 0;
    p_din = '0; p_vld = 0; p_rdy_dn = 0; p_flush = 0;
    @(negedge clk); #1;
    total++; if (d_vout !== 1'b0) begin bad++; $display("FAIL rst_d_vld got %0h want 0", d_vout); end
    total++; if (d_rdy_up !== 1'b0) begin bad++; $display("FAIL rst_d_rdy got %0h want 0", d_rdy_up); end
    total++; if (d_lvl !== 3'd0) begin bad++; $display("FAIL rst_d_lvl got %0h want 0", d_lvl); end
    total++; if (d_dout !== 32'h0) begin bad++; $display("FAIL rst_d_dout got %0h want 0", d_dout); end
    total++; if (d_sl !== 3'd0) begin bad++; $display("FAIL rst_d_sl got %0h want 0", d_sl); end
    total++; if (u_vout !== 1'b0) begin bad++; $display("FAIL rst_u_vld got %0h want 0", u_vout); end
    total++; if (u_dout !== 128'h0) begin bad++; $display("FAIL rst_u_dout got %0h want 0", u_dout); end
    total++; if (u_sl !== 3'd0) begin bad++; $display("FAIL rst_u_sl got %0h want 0", u_sl); end
    total++; if (p_rdy_up !== 1'b0) begin bad++; $display("FAIL rst_p_rdy got %0h want 0", p_rdy_up); end
    @(negedge clk); reset = 1'b0;
    #1;
    total++; if (d_rdy_up !== 1'b1) begin bad++; $display("FAIL post_rst_rdy got %0h want 1", d_rdy_up); end
  endtask

  task automatic test_down();
    logic [31:0] exp_d [4];
    exp_d = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    @(negedge clk);
    d_din = 128'h44444444_33333333_22222222_11111111;
    d_vld = 1; d_rdy_dn = 1;
    @(negedge clk); d_vld = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++;
      if (d_vout !== 1'b1 || d_dout !== exp_d[i] || d_sl !== 3'd1) begin
        bad++; $display("FAIL down_beat%0d got v=%0h d=%h s=%0d want v=1 d=%h s=1", i, d_vout, d_dout, d_sl, exp_d[i]);
      end
      @(negedge clk);
    end
    #1;
    total++; if (d_vout !== 1'b0 || d_lvl !== 3'd0) begin bad++; $display("FAIL down_empty got v=%0h l=%0d want v=0 l=0", d_vout, d_lvl); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    d_din = 128'h88888888_77777777_66666666_55555555;
    d_vld = 1; d_rdy_dn = 1;
    @(negedge clk); d_vld = 0;
    @(negedge clk);
    @(negedge clk); #1;
    total++; if (d_dout !== 32'h77777777) begin bad++; $display("FAIL mid_slice2 got %h want 77777777", d_dout); end
    reset = 1'b1; #1;
    total++;
    if (d_vout !== 1'b0 || d_lvl !== 3'd0 || d_dout !== 32'h0 || d_rdy_up !== 1'b0 || d_sl !== 3'd0) begin
      bad++; $display("FAIL mid_reset got v=%0h l=%0d d=%h r=%0h s=%0d want all 0", d_vout, d_lvl, d_dout, d_rdy_up, d_sl);
    end
    @(negedge clk); reset = 1'b0;
    d_din = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA; d_vld = 1;
    @(negedge clk); d_vld = 0; #1;
    total++; if (d_vout !== 1'b1 || d_dout !== 32'hAAAAAAAA) begin bad++; $display("FAIL mid_restart got v=%0h d=%h want v=1 d=aaaaaaaa", d_vout, d_dout); end
    for (int i = 0; i < 4; i++) @(negedge clk);
    #1;
    total++; if (d_lvl !== 3'd0) begin bad++; $display("FAIL mid_drain got %0d want 0", d_lvl); end
  endtask

  task automatic test_backpressure();
    d_rdy_dn = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      d_din = mkw(i); d_vld = 1; #1;
      total++;
      if (d_rdy_up !== (i < 4)) begin bad++; $display("FAIL bp_rdy%0d got %0h want %0h", i, d_rdy_up, (i < 4)); end
    end
    @(negedge clk); d_vld = 0; #1;
    total++;
    if (d_lvl !== 3'd4 || d_rdy_up !== 1'b0 || d_vout !== 1'b1 || d_dout !== slc(0, 0)) begin
      bad++; $display("FAIL bp_full got l=%0d r=%0h v=%0h d=%h want l=4 r=0 v=1 d=%h", d_lvl, d_rdy_up, d_vout, d_dout, slc(0, 0));
    end
    d_rdy_dn = 1;
    for (int n = 0; n < 16; n++) begin
      #1;
      total++;
      if (d_vout !== 1'b1 || d_dout !== slc(n / 4, n % 4)) begin
        bad++; $display("FAIL bp_beat%0d got v=%0h d=%h want v=1 d=%h", n, d_vout, d_dout, slc(n / 4, n % 4));
      end
      @(negedge clk);
    end
    #1;
    total++; if (d_vout !== 1'b0 || d_lvl !== 3'd0) begin bad++; $display("FAIL bp_drained got v=%0h l=%0d want 0 0", d_vout, d_lvl); end
  endtask

  task automatic test_apstart();
    @(negedge clk);
    d_din = mkw(7); d_vld = 1; d_rdy_dn = 1;
    @(negedge clk); d_vld = 0; #1;
    total++; if (d_dout !== slc(7, 0)) begin bad++; $display("FAIL ap_s0 got %h want %h", d_dout, slc(7, 0)); end
    @(negedge clk);
    ap_start = 0; d_din = mkw(8); d_vld = 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++;
      if (d_vout !== 1'b0 || d_rdy_up !== 1'b0 || d_dout !== slc(7, 1) || d_lvl !== 3'd1) begin
        bad++; $display("FAIL ap_hold%0d got v=%0h r=%0h d=%h l=%0d want v=0 r=0 d=%h l=1", k, d_vout, d_rdy_up, d_dout, d_lvl, slc(7, 1));
      end
      @(negedge clk);
    end
    ap_start = 1; d_vld = 0;
    for (int j = 1; j < 4; j++) begin
      #1;
      total++;
      if (d_vout !== 1'b1 || d_dout !== slc(7, j)) begin
        bad++; $display("FAIL ap_resume%0d got v=%0h d=%h want v=1 d=%h", j, d_vout, d_dout, slc(7, j));
      end
      @(negedge clk);
    end
    #1;
    total++; if (d_lvl !== 3'd0) begin bad++; $display("FAIL ap_drain got %0d want 0", d_lvl); end
  endtask

  task automatic test_up();
    int n;
    u_rdy_dn = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      u_din = 32'hA + 32'(i); u_vld = 1;
    end
    @(negedge clk); u_vld = 0; #1;
    n = 0;
    while (u_vout !== 1'b1 && n < 10) begin
      @(negedge clk); #1; n++;
    end
    total++; if (u_vout !== 1'b1) begin bad++; $display("FAIL up_timeout got v=%0h want 1", u_vout); end
    total++;
    if (u_dout !== 128'h0000000D_0000000C_0000000B_0000000A) begin
      bad++; $display("FAIL up_data got %h want 0000000d0000000c0000000b0000000a", u_dout);
    end
    total++; if (u_sl !== 3'd4) begin bad++; $display("FAIL up_slices got %0d want 4", u_sl); end
    @(negedge clk); #1;
    total++; if (u_vout !== 1'b0) begin bad++; $display("FAIL up_single got %0h want 0", u_vout); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      u_din = 32'(i + 1); u_vld = 1;
    end
    @(negedge clk); u_vld = 0;
    @(negedge clk); #1;
    total++; if (u_vout !== 1'b0 || u_lvl !== 3'd0) begin bad++; $display("FAIL fl_pre got v=%0h l=%0d want 0 0", u_vout, u_lvl); end
    u_flush = 1;
    @(negedge clk); #1;
    total++;
    if (u_vout !== 1'b1 || u_dout !== 128'h00000000_00000000_00000002_00000001 || u_sl !== 3'd2) begin
      bad++; $display("FAIL fl_word got v=%0h d=%h s=%0d want v=1 d=...0000000200000001 s=2", u_vout, u_dout, u_sl);
    end
    @(negedge clk); #1;
    total++; if (u_vout !== 1'b0) begin bad++; $display("FAIL fl_empty got %0h want 0", u_vout); end
    u_flush = 0;
  endtask

  task automatic test_pass();
    @(negedge clk);
    p_din = 32'h12345678; p_vld = 1; p_rdy_dn = 1;
    @(negedge clk); p_vld = 0; #1;
    total++;
    if (p_vout !== 1'b1 || p_dout !== 32'h12345678 || p_sl !== 1'b1) begin
      bad++; $display("FAIL pass_word got v=%0h d=%h s=%0d want v=1 d=12345678 s=1", p_vout, p_dout, p_sl);
    end
    @(negedge clk); #1;
    total++; if (p_vout !== 1'b0 || p_lvl !== 3'd0) begin bad++; $display("FAIL pass_empty got v=%0h l=%0d want 0 0", p_vout, p_lvl); end
  endtask

  initial begin
    test_reset();
    test_down();
    test_reset_mid();
    test_backpressure();
    test_apstart();
    test_up();
    test_flush();
    test_pass();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
